// File: rtl/btn_cond_pkg.sv
// btn_cond shared types and default timing.
// Phase encoding for auto-repeat and the raw pulse bundle.
package btn_cond_pkg;

    localparam int CNT_W_DFLT         = 22;
    localparam int DB_CYCLES_DFLT     = 50000;
    localparam int REPEAT_DELAY_DFLT  = 3000000;
    localparam int REPEAT_PERIOD_DFLT = 1000000;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        PERIOD
    } rpt_phase_t;

    typedef struct packed {
        logic fire;
        logic aim_r;
        logic aim_l;
        logic right;
        logic left;
    } btn_vec_t;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 2-FF sync, debounce,
// press-edge detect and optional hold-to-repeat.
module btn_chan
    import btn_cond_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DFLT,
    parameter int DB_CYCLES     = DB_CYCLES_DFLT,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DFLT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic raw_pulse
);

    localparam logic [CNT_W-1:0] DB_MAX =
        CNT_W'(DB_CYCLES - 1);

    logic             sync_ff;
    logic             sync_q;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             flip;
    logic             rise;
    logic             fall;
    logic             rpt_hit;

    assign flip = (sync_q != stable) && (cnt == DB_MAX);
    assign rise = flip && sync_q;
    assign fall = flip && !sync_q;

    // Bring the asynchronous level into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            sync_ff <= btn;
            sync_q  <= sync_ff;
        end
    end

    // Flip stable only after DB_CYCLES consecutive disagreements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync_q == stable) begin
            cnt <= '0;
        end else if (cnt == DB_MAX) begin
            stable <= sync_q;
            cnt    <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    generate
        if (REPEAT_EN) begin : g_rpt
            localparam logic [CNT_W-1:0] RD_MAX =
                CNT_W'(REPEAT_DELAY - 1);
            localparam logic [CNT_W-1:0] RP_MAX =
                CNT_W'(REPEAT_PERIOD - 1);

            rpt_phase_t       phase;
            logic [CNT_W-1:0] rpt_cnt;

            // A falling edge wins over a repeat boundary.
            always_comb begin
                rpt_hit = 1'b0;
                if (stable && !fall) begin
                    unique case (1'b1)
                        (phase == DELAY):
                            rpt_hit = (rpt_cnt == RD_MAX);
                        (phase == PERIOD):
                            rpt_hit = (rpt_cnt == RP_MAX);
                        default:
                            rpt_hit = 1'b0;
                    endcase
                end
            end

            // Repeat timer restarts on press, stops on release.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    phase   <= IDLE;
                    rpt_cnt <= '0;
                end else if (rise) begin
                    phase   <= DELAY;
                    rpt_cnt <= '0;
                end else if (fall) begin
                    phase   <= IDLE;
                    rpt_cnt <= '0;
                end else if (stable) begin
                    if (rpt_hit) begin
                        phase   <= PERIOD;
                        rpt_cnt <= '0;
                    end else begin
                        rpt_cnt <= rpt_cnt + 1'b1;
                    end
                end
            end
        end else begin : g_no_rpt
            assign rpt_hit = 1'b0;
        end
    endgenerate

    // One-cycle pulse on press or repeat boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_pulse <= 1'b0;
        end else begin
            raw_pulse <= rise | rpt_hit;
        end
    end

endmodule

// File: rtl/btn_cond.sv
// Five-button conditioner with opposing-direction
// conflict suppression on the registered outputs.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DFLT,
    parameter int DB_CYCLES     = DB_CYCLES_DFLT,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DFLT,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DFLT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_aim_l,
    input  logic btn_aim_r,
    input  logic btn_fire,
    output logic left_x,
    output logic right_x,
    output logic left_aim,
    output logic right_aim,
    output logic fire
);

    btn_vec_t raw;

    btn_chan #(
        .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES),
        .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_left (
        .clk(clk), .rst_n(rst_n),
        .btn(btn_left), .raw_pulse(raw.left)
    );

    btn_chan #(
        .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES),
        .REPEAT_EN(1'b1),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_right (
        .clk(clk), .rst_n(rst_n),
        .btn(btn_right), .raw_pulse(raw.right)
    );

    btn_chan #(
        .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES),
        .REPEAT_EN(1'b0),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_aim_l (
        .clk(clk), .rst_n(rst_n),
        .btn(btn_aim_l), .raw_pulse(raw.aim_l)
    );

    btn_chan #(
        .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES),
        .REPEAT_EN(1'b0),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_aim_r (
        .clk(clk), .rst_n(rst_n),
        .btn(btn_aim_r), .raw_pulse(raw.aim_r)
    );

    btn_chan #(
        .CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES),
        .REPEAT_EN(1'b0),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_fire (
        .clk(clk), .rst_n(rst_n),
        .btn(btn_fire), .raw_pulse(raw.fire)
    );

    // Drop simultaneous opposing pulses; fire passes through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_x    <= 1'b0;
            right_x   <= 1'b0;
            left_aim  <= 1'b0;
            right_aim <= 1'b0;
            fire      <= 1'b0;
        end else begin
            left_x    <= raw.left  & ~raw.right;
            right_x   <= raw.right & ~raw.left;
            left_aim  <= raw.aim_l & ~raw.aim_r;
            right_aim <= raw.aim_r & ~raw.aim_l;
            fire      <= raw.fire;
        end
    end

endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond against a
// sample-history reference model.
module tb_btn_cond;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] btn   = '0;
    logic       left_x, right_x, left_aim;
    logic       right_aim, fire;

    int compared   = 0;
    int mismatched = 0;

    logic [4:0] expq[$];
    int         pc[5];
    int         last_cyc[5];
    int         mcyc = 0;

    int         hist[5][$];
    int         run[5][$];
    logic [4:0] stab;
    logic [4:0] prevp;
    int         press_at[5];
    int         edge_n = 0;

    btn_cond #(
        .CNT_W(22),
        .DB_CYCLES(DB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_left(btn[0]),
        .btn_right(btn[1]),
        .btn_aim_l(btn[2]),
        .btn_aim_r(btn[3]),
        .btn_fire(btn[4]),
        .left_x(left_x),
        .right_x(right_x),
        .left_aim(left_aim),
        .right_aim(right_aim),
        .fire(fire)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs_now();
        return {fire, right_aim, left_aim, right_x, left_x};
    endfunction

    task automatic chk(string nm, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d",
                     nm, act, exp);
        end
    endtask

    // Reference: a level change is accepted once DB
    // consecutive synchronised samples (raw delayed two
    // edges) disagree with the accepted level.
    task automatic model_step();
        logic [4:0] exp;
        logic [4:0] cur;
        int         sv;
        int         d;
        bit         flip;
        bit         was;
        if (!rst_n) begin
            for (int c = 0; c < 5; c++) begin
                hist[c] = {0, 0};
                run[c].delete();
                press_at[c] = 0;
            end
            stab  = '0;
            prevp = '0;
            exp   = '0;
        end else begin
            exp[0] = prevp[0] && !prevp[1];
            exp[1] = prevp[1] && !prevp[0];
            exp[2] = prevp[2] && !prevp[3];
            exp[3] = prevp[3] && !prevp[2];
            exp[4] = prevp[4];
            cur = '0;
            for (int c = 0; c < 5; c++) begin
                sv = hist[c][0];
                void'(hist[c].pop_front());
                hist[c].push_back(int'(btn[c]));
                run[c].push_back(sv);
                if (run[c].size() > DB)
                    void'(run[c].pop_front());
                flip = (run[c].size() == DB);
                foreach (run[c][k])
                    if (run[c][k] == int'(stab[c]))
                        flip = 1'b0;
                was = stab[c];
                if (flip) begin
                    stab[c] = ~stab[c];
                    run[c].delete();
                end
                if (flip && stab[c]) begin
                    cur[c] = 1'b1;
                    press_at[c] = edge_n;
                end else if (c < 2 && was && !flip) begin
                    d = edge_n - press_at[c];
                    if (d == RD ||
                        (d > RD && (d - RD) % RP == 0))
                        cur[c] = 1'b1;
                end
            end
            prevp = cur;
        end
        expq.push_back(exp);
        edge_n++;
    endtask

    initial begin
        for (int c = 0; c < 5; c++) begin
            hist[c] = {0, 0};
            pc[c] = 0;
            last_cyc[c] = -1;
        end
        stab  = '0;
        prevp = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: one expected vector per clock edge.
    initial begin
        logic [4:0] e;
        logic [4:0] a;
        forever begin
            @(negedge clk);
            mcyc++;
            a = outs_now();
            for (int c = 0; c < 5; c++)
                if (a[c]) begin
                    pc[c]++;
                    last_cyc[c] = mcyc;
                end
            if (expq.size() != 0) begin
                e = expq.pop_front();
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL outs cyc %0d: got %b, expected %b",
                             mcyc, a, e);
                end
            end
        end
    end

    task automatic tick(int k);
        repeat (k) @(negedge clk);
        #2;
    endtask

    initial begin
        int b0, b1;
        int t;
        int rem[5];
        // Reset with fire held through release.
        btn[4] = 1'b1;
        tick(3);
        chk("rst_outs", int'(outs_now()), 0);
        b0 = pc[4];
        rst_n = 1'b1;
        tick(6 + 50);
        chk("hold_fire_once", pc[4] - b0, 1);
        btn[4] = 1'b0;
        tick(10);

        // Bounce on aim_l, then a steady hold.
        b0 = pc[2];
        b1 = pc[3];
        t = 0;
        while (t < 20) begin
            btn[2] = 1'b1;
            tick(3);
            btn[2] = 1'b0;
            tick($urandom_range(3, 1));
            t += 4;
        end
        chk("bounce_quiet", pc[2] - b0, 0);
        btn[2] = 1'b1;
        tick(20);
        chk("bounce_one", pc[2] - b0, 1);
        chk("bounce_r_aim", pc[3] - b1, 0);
        btn[2] = 1'b0;
        tick(10);

        // Hold right through several repeats.
        b0 = pc[1];
        b1 = pc[0];
        btn[1] = 1'b1;
        tick(36);
        btn[1] = 1'b0;
        tick(12);
        chk("rpt_count", pc[1] - b0, 11);
        chk("rpt_no_left", pc[0] - b1, 0);

        // Opposing directions pressed together.
        b0 = pc[0];
        b1 = pc[1];
        btn[1:0] = 2'b11;
        tick(30);
        chk("conf_left", pc[0] - b0, 0);
        chk("conf_right", pc[1] - b1, 0);
        btn[1] = 1'b0;
        tick(20);
        btn[0] = 1'b0;
        tick(12);

        // Reset in the middle of the repeat period.
        btn[0] = 1'b1;
        tick(19);
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", int'(outs_now()), 0);
        tick(1);
        rst_n = 1'b1;
        tick(40);
        btn[0] = 1'b0;
        tick(12);

        // Fire and aim-right together.
        b0 = pc[4];
        b1 = pc[3];
        btn[4:3] = 2'b11;
        tick(15);
        chk("ind_fire", pc[4] - b0, 1);
        chk("ind_raim", pc[3] - b1, 1);
        chk("ind_same_cyc", last_cyc[4], last_cyc[3]);
        btn[4:3] = 2'b00;
        tick(12);

        // Random holds and glitches on all buttons.
        for (int c = 0; c < 5; c++) rem[c] = 1;
        for (int i = 0; i < 4000; i++) begin
            for (int c = 0; c < 5; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    btn[c] = ~btn[c];
                    rem[c] = $urandom_range(30, 1);
                end
            end
            if ($urandom_range(599, 0) == 0) begin
                rst_n = 1'b0;
                tick(1);
                rst_n = 1'b1;
            end
            tick(1);
        end
        btn = '0;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
